line_burst_adaptor: RTL and testbench
=====================================

LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have parameter s_line, default 256, cache line width in bits.
REQ-002 SHALL have parameter s_burst, default 64, memory beat width in bits; s_line/s_burst = beats per line.
REQ-003 SHALL have parameter s_offset, default 5, line offset bits.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles.
REQ-005 SHALL have ports:
  clk  input  1  clock, all state on rising edge
  rst  input  1  synchronous, active-high reset
  line_read  input  1  line read request, held until line_resp
  line_write  input  1  line write request, held until line_resp
  line_address  input  32  line address
  line_wdata  input  s_line  write line
  line_resp  output  1  one-cycle completion pulse
  line_rdata  output  s_line  assembled read line, valid when line_resp
  mem_read  output  1  burst read request
  mem_write  output  1  burst write request
  mem_address  output  32  line-aligned burst address
  mem_wdata  output  s_burst  current write beat
  mem_rdata  input  s_burst  current read beat
  mem_resp  input  1  one beat transferred this cycle
  error  output  1  sticky watchdog flag

Function
REQ-006 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-007 In IDLE, line_read SHALL move to READ; line_write, if line_read is low, SHALL move to WRITE; with both high, read SHALL win.
REQ-008 On acceptance SHALL latch {line_address[31:s_offset], s_offset zeros} and line_wdata; later line-side input changes SHALL be ignored until DONE.
REQ-009 mem_read SHALL equal (state==READ); mem_write SHALL equal (state==WRITE); mem_address SHALL come from the latched address.
REQ-010 Beat k SHALL map to line bits [k*s_burst +: s_burst], beat 0 first.
REQ-011 SHALL keep a beat counter, 0 at entry to READ/WRITE; each cycle with mem_resp high SHALL increment it and transfer one beat; cycles with mem_resp low SHALL hold all state.
REQ-012 In READ, mem_rdata SHALL be stored into beat slot[counter] on mem_resp.
REQ-013 In WRITE, mem_wdata SHALL equal latched line beat[counter] combinationally.
REQ-014 The last beat's mem_resp SHALL move to DONE; mem_read/mem_write SHALL be low in the following cycle.
REQ-015 In DONE, line_resp SHALL be 1 for exactly one cycle and then go to IDLE; line_rdata SHALL hold the assembled line from DONE until the next read accept.
REQ-016 Minimum latency with 4 back-to-back beats SHALL be: request seen in IDLE at cycle N, READ/WRITE N+1..N+4, line_resp at N+5.
REQ-017 A request still held in the IDLE cycle after DONE SHALL be accepted as a new request.
REQ-018 mem_resp in IDLE or DONE SHALL be ignored.

Reset
REQ-019 rst SHALL force IDLE, counter 0, error 0, line_rdata 0 and latched address/data 0; outputs SHALL be line_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
REQ-020 rst during READ/WRITE SHALL abort the burst with no line_resp; rst has priority over every other event.

Configuration
REQ-021 With macro LINE_BURST_ADAPTOR_WATCHDOG_EN defined, a counter SHALL count consecutive READ/WRITE cycles with mem_resp low, clear on mem_resp, and at TIMEOUT_CYCLES SHALL set error (sticky until rst) and go to DONE; for reads, unreceived beats SHALL be 0.
REQ-022 Without the macro, error SHALL be tied to 0, the counter SHALL be absent, and a stalled burst SHALL wait indefinitely.

Structure
REQ-023 The FSM state enum and the beats-per-line constant SHALL go in a shared package with the cache hierarchy typedefs.
REQ-024 The beat shift/assemble buffer SHALL be one sub-module, line_beat_buffer; FSM and counters stay in the top.

Verification
REQ-025 Read, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles -> mem_address 0x0000_1220, line_resp at N+5, line_rdata = {0x44..,0x33..,0x22..,0x11..}.
REQ-026 Write line 0xAAAA..BBBB.. with mem_resp low for 3 cycles between beats 1 and 2 -> mem_wdata holds beat 2 during the stall, 4 beats in order, one line_resp.
REQ-027 line_read and line_write both high in IDLE -> mem_read=1, mem_write=0.
REQ-028 rst asserted after beat 2 of a read -> next cycle IDLE, mem_read=0, no line_resp; a new read then completes normally.
REQ-029 Request held through DONE -> second burst starts in the IDLE cycle after line_resp, with no lost or duplicate line_resp.
REQ-030 With LINE_BURST_ADAPTOR_WATCHDOG_EN and TIMEOUT_CYCLES=8, mem_resp never high -> error=1 and line_resp after 8 stall cycles; error stays 1 until rst.

Source files
------------

// File: rtl/line_burst_adaptor_pkg.sv
// Shared types and constants for the line-to-burst adaptor.
// Holds the FSM state enum, the beats-per-line constant and the cache
// hierarchy typedefs used by line_burst_adaptor and line_beat_buffer.
package line_burst_adaptor_pkg;

  // Adaptor control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lba_state_e;

  // Default cache hierarchy geometry.
  localparam int LINE_BITS_DEF   = 256;
  localparam int BURST_BITS_DEF  = 64;
  localparam int OFFSET_BITS_DEF = 5;
  localparam int BEATS_PER_LINE  = LINE_BITS_DEF / BURST_BITS_DEF;

  // Cache hierarchy typedefs at the default geometry.
  typedef logic [31:0]                mem_addr_t;
  typedef logic [LINE_BITS_DEF-1:0]   cache_line_t;
  typedef logic [BURST_BITS_DEF-1:0]  mem_beat_t;

  // Beats needed to move one line for an arbitrary geometry.
  function automatic int beats_per_line(input int line_bits, input int burst_bits);
    return line_bits / burst_bits;
  endfunction

  // Width of a counter that indexes n beats (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_burst_adaptor_beat_buffer.sv
// line_beat_buffer: holds the latched write line and assembles the read
// line beat by beat. Beat k occupies line bits [k*s_burst +: s_burst].
module line_beat_buffer
  import line_burst_adaptor_pkg::*;
#(
  parameter int s_line  = 256,
  parameter int s_burst = 64,
  parameter int BEATS   = beats_per_line(s_line, s_burst),
  parameter int CW      = cnt_width(BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [s_line-1:0]  i_wline,
  input  logic               i_clear,
  input  logic               i_store,
  input  logic [CW-1:0]      i_idx,
  input  logic [s_burst-1:0] i_beat,
  output logic [s_line-1:0]  o_rline,
  output logic [s_burst-1:0] o_wbeat
);

  logic [s_line-1:0]  r_wline;
  logic [s_line-1:0]  r_rline;
  logic [s_burst-1:0] w_wbeat;

  // Capture the write line when a request is accepted.
  // NOTE: these line-wide registers are reset on purpose: the reset value of
  // the assembled line is visible on line_rdata, and a cleared write latch
  // keeps mem_wdata at zero out of reset.
  always_ff @(posedge clk) begin
    if (rst)         r_wline <= '0;
    else if (i_load) r_wline <= i_wline;
  end

  // Assemble read beats; cleared on read accept so unreceived beats read as 0.
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rline <= '0;
    end else if (i_clear) begin
      r_rline <= '0;
    end else if (i_store) begin
      for (int k = 0; k < BEATS; k++) begin
        if (i_idx == CW'(k)) r_rline[k*s_burst +: s_burst] <= i_beat;
      end
    end
  end

  // Select the current write beat from the latched line.
  // NOTE: the default assignment first means every path drives w_wbeat,
  // so no latch is inferred.
  always_comb begin
    w_wbeat = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (i_idx == CW'(k)) w_wbeat = r_wline[k*s_burst +: s_burst];
    end
  end

  assign o_rline = r_rline;
  assign o_wbeat = w_wbeat;

endmodule

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: converts a cache line read/write request into a burst
// of s_line/s_burst memory beats, beat 0 first, and returns a one-cycle
// line_resp when the burst completes.
// Optional feature: define LINE_BURST_ADAPTOR_WATCHDOG_EN to add a stall
// watchdog that aborts a burst after TIMEOUT_CYCLES idle-beat cycles and
// raises a sticky error flag.
module line_burst_adaptor
  import line_burst_adaptor_pkg::*;
#(
  parameter int s_line         = 256,
  parameter int s_burst        = 64,
  parameter int s_offset       = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [s_line-1:0]  line_wdata,
  output logic               line_resp,
  output logic [s_line-1:0]  line_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [31:0]        mem_address,
  output logic [s_burst-1:0] mem_wdata,
  input  logic [s_burst-1:0] mem_rdata,
  input  logic               mem_resp,
  output logic               error
);

  localparam int LINE_BEATS = beats_per_line(s_line, s_burst);
  localparam int CW         = cnt_width(LINE_BEATS);
  localparam mem_addr_t OFFSET_MASK = mem_addr_t'((64'd1 << s_offset) - 64'd1);

  lba_state_e r_state;
  lba_state_e w_next;
  logic [CW-1:0] r_beat;
  mem_addr_t     r_addr;

  logic w_accept_rd;
  logic w_accept_wr;
  logic w_accept;
  logic w_busy;
  logic w_xfer;
  logic w_last;
  logic w_timeout;

  // Read wins when both requests are present in IDLE.
  assign w_accept_rd = (r_state == IDLE) && line_read;
  assign w_accept_wr = (r_state == IDLE) && !line_read && line_write;
  assign w_accept    = w_accept_rd || w_accept_wr;
  assign w_busy      = (r_state == READ) || (r_state == WRITE);
  assign w_xfer      = w_busy && mem_resp;
  assign w_last      = w_xfer && (r_beat == CW'(LINE_BEATS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (line_read)       w_next = READ;
        else if (line_write) w_next = WRITE;
      end
      READ, WRITE: begin
        if (w_last || w_timeout) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Beat counter: zeroed on accept, advances once per transferred beat.
  always_ff @(posedge clk) begin
    if (rst)           r_beat <= '0;
    else if (w_accept) r_beat <= '0;
    else if (w_xfer)   r_beat <= r_beat + CW'(1);
  end

  // Latch the line-aligned address on accept; ignore it until the next one.
  always_ff @(posedge clk) begin
    if (rst)           r_addr <= '0;
    else if (w_accept) r_addr <= line_address & ~OFFSET_MASK;
  end

`ifdef LINE_BURST_ADAPTOR_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] r_wd;
  logic          r_error;

  assign w_timeout = w_busy && !mem_resp && (r_wd == WW'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled busy cycles; flag and abort at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd    <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_busy && !mem_resp && !w_timeout) r_wd <= r_wd + WW'(1);
      else                                   r_wd <= '0;
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  // Watchdog compiled out: a stalled burst waits forever. The comparison
  // folds to 0 for any legal limit and keeps the shared parameter list live.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
  assign error     = 1'b0;
`endif

  line_beat_buffer #(
    .s_line  (s_line),
    .s_burst (s_burst),
    .BEATS   (LINE_BEATS),
    .CW      (CW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_wline (line_wdata),
    .i_clear (w_accept_rd),
    .i_store ((r_state == READ) && mem_resp),
    .i_idx   (r_beat),
    .i_beat  (mem_rdata),
    .o_rline (line_rdata),
    .o_wbeat (mem_wdata)
  );

  assign mem_read    = (r_state == READ);
  assign mem_write   = (r_state == WRITE);
  assign mem_address = r_addr;
  assign line_resp   = (r_state == DONE);

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed testbench for line_burst_adaptor (default geometry: 4 x 64-bit
// beats per 256-bit line). Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_line_burst_adaptor;

`ifdef LINE_BURST_ADAPTOR_WATCHDOG_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic         clk;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic         line_resp;
  logic [255:0] line_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;
  logic         error;

  line_burst_adaptor #(
    .s_line(256), .s_burst(64), .s_offset(5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_resp    (line_resp),
    .line_rdata   (line_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int resp_cnt = 0;

  // Count line_resp pulses (value before the edge updates it).
  always @(posedge clk) if (line_resp === 1'b1) resp_cnt++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Plain 4-beat read from IDLE, checking latency and assembled data.
  task automatic read_burst(input string tag, input logic [31:0] addr, input logic [255:0] l);
    logic [255:0] lv;
    lv = l;
    @(negedge clk);
    line_read = 1'b1; line_address = addr; mem_resp = 1'b0;
    @(negedge clk);
    check({tag, " mem_read"}, mem_read, 1'b1);
    for (int k = 0; k < 4; k++) begin
      mem_resp = 1'b1; mem_rdata = lv[k*64 +: 64];
      @(negedge clk);
    end
    check({tag, " line_resp"}, line_resp, 1'b1);
    check({tag, " line_rdata"}, line_rdata, lv);
    line_read = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    check({tag, " line_resp low"}, line_resp, 1'b0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic        mresp;
    logic [63:0] rdata;
    logic [31:0] addr;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_lresp;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t         vt [7];
  logic [63:0]  wb [4];
  logic [255:0] wl;
  logic [255:0] exp_line;
  int           cnt0;

  initial begin
    // Read 0x1234: beats 0x11.., 0x22.., 0x33.., 0x44.. back to back.
    // The address changes after accept and must be ignored.
    vt[0] = '{1'b1, 1'b0, 1'b0, 64'h0,                   32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 64'h1111_1111_1111_1111, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_1220};
    vt[2] = '{1'b1, 1'b0, 1'b1, 64'h2222_2222_2222_2222, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_1220};
    vt[3] = '{1'b1, 1'b0, 1'b1, 64'h3333_3333_3333_3333, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_1220};
    vt[4] = '{1'b1, 1'b0, 1'b1, 64'h4444_4444_4444_4444, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_1220};
    vt[5] = '{1'b0, 1'b0, 1'b0, 64'h0,                   32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_1220};
    vt[6] = '{1'b0, 1'b0, 1'b0, 64'h0,                   32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_1220};

    // Reset state.
    rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_address = '0;
    line_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("rst line_resp", line_resp, 1'b0);
    check("rst mem_read", mem_read, 1'b0);
    check("rst mem_write", mem_write, 1'b0);
    check("rst mem_address", mem_address, 32'h0);
    check("rst mem_wdata", mem_wdata, 64'h0);
    check("rst line_rdata", line_rdata, 256'h0);
    check("rst error", error, 1'b0);
    rst = 1'b0;

    // Table-driven read: check outputs of this cycle, then drive its inputs.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d mem_read", i), mem_read, vt[i].exp_rd);
      check($sformatf("vec%0d mem_write", i), mem_write, vt[i].exp_wr);
      check($sformatf("vec%0d line_resp", i), line_resp, vt[i].exp_lresp);
      check($sformatf("vec%0d mem_address", i), mem_address, vt[i].exp_addr);
      line_read = vt[i].rd; line_write = vt[i].wr; mem_resp = vt[i].mresp;
      mem_rdata = vt[i].rdata; line_address = vt[i].addr;
    end
    @(negedge clk);
    check("vec line_rdata held", line_rdata,
          256'h4444_4444_4444_4444_3333_3333_3333_3333_2222_2222_2222_2222_1111_1111_1111_1111);

    // Write with a 3-cycle stall between beats 1 and 2.
    wb[0] = 64'hAAAA_AAAA_BBBB_BBB0; wb[1] = 64'hAAAA_AAAA_BBBB_BBB1;
    wb[2] = 64'hAAAA_AAAA_BBBB_BBB2; wb[3] = 64'hAAAA_AAAA_BBBB_BBB3;
    wl = {wb[3], wb[2], wb[1], wb[0]};
    cnt0 = resp_cnt;
    line_write = 1'b1; line_wdata = wl; line_address = 32'h0000_5678; mem_resp = 1'b0;
    @(negedge clk);
    check("wr mem_write", mem_write, 1'b1);
    check("wr mem_read", mem_read, 1'b0);
    check("wr mem_address", mem_address, 32'h0000_5660);
    check("wr beat0", mem_wdata, wb[0]);
    line_wdata = '1; line_address = '0; mem_resp = 1'b1;
    @(negedge clk);
    check("wr beat1", mem_wdata, wb[1]);
    mem_resp = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("wr stall%0d beat2", s), mem_wdata, wb[2]);
      check($sformatf("wr stall%0d mem_write", s), mem_write, 1'b1);
      mem_resp = 1'b0;
    end
    @(negedge clk);
    check("wr beat2", mem_wdata, wb[2]);
    mem_resp = 1'b1;
    @(negedge clk);
    check("wr beat3", mem_wdata, wb[3]);
    mem_resp = 1'b1;
    @(negedge clk);
    check("wr line_resp", line_resp, 1'b1);
    check("wr mem_write low", mem_write, 1'b0);
    line_write = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    check("wr line_resp low", line_resp, 1'b0);
    check("wr resp count", resp_cnt - cnt0, 1);

    // Both requests high in IDLE, with a stray mem_resp in IDLE.
    line_read = 1'b1; line_write = 1'b1; line_address = 32'h0000_0040; mem_resp = 1'b1;
    mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    check("both mem_read", mem_read, 1'b1);
    check("both mem_write", mem_write, 1'b0);
    check("both mem_address", mem_address, 32'h0000_0040);
    line_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_resp = 1'b1; mem_rdata = 64'hC0C0_0000_0000_0000 + 64'(k);
      @(negedge clk);
    end
    check("both line_resp", line_resp, 1'b1);
    check("both line_rdata", line_rdata,
          {64'hC0C0_0000_0000_0003, 64'hC0C0_0000_0000_0002,
           64'hC0C0_0000_0000_0001, 64'hC0C0_0000_0000_0000});
    line_read = 1'b0; mem_resp = 1'b0;
    @(negedge clk);

    // Reset in the middle of a read, after two beats.
    cnt0 = resp_cnt;
    line_read = 1'b1; line_address = 32'h0000_0100;
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    mem_rdata = 64'h6666_6666_6666_6666;
    @(negedge clk);
    check("abort mem_read before rst", mem_read, 1'b1);
    rst = 1'b1; line_read = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    check("abort mem_read", mem_read, 1'b0);
    check("abort line_resp", line_resp, 1'b0);
    check("abort mem_address", mem_address, 32'h0);
    check("abort line_rdata", line_rdata, 256'h0);
    rst = 1'b0;
    @(negedge clk);
    check("abort no line_resp", resp_cnt - cnt0, 0);
    read_burst("after abort", 32'h0000_0180,
               256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_0F0F_F0F0_F0F0_1357_9BDF_2468_ACE0);

    // Request held through DONE: a second burst starts from the next IDLE.
    cnt0 = resp_cnt;
    exp_line = 256'h0;
    line_read = 1'b1; line_address = 32'h0000_2000;
    @(negedge clk);
    check("held burst1 mem_read", mem_read, 1'b1);
    for (int k = 0; k < 4; k++) begin
      mem_resp = 1'b1; mem_rdata = 64'hA100_0000_0000_0000 + 64'(k);
      @(negedge clk);
    end
    check("held burst1 line_resp", line_resp, 1'b1);
    mem_resp = 1'b0;
    @(negedge clk);
    check("held idle line_resp", line_resp, 1'b0);
    check("held idle mem_read", mem_read, 1'b0);
    @(negedge clk);
    check("held burst2 mem_read", mem_read, 1'b1);
    for (int k = 0; k < 4; k++) begin
      mem_resp = 1'b1; mem_rdata = 64'hB200_0000_0000_0000 + 64'(k);
      exp_line[k*64 +: 64] = 64'hB200_0000_0000_0000 + 64'(k);
      @(negedge clk);
    end
    check("held burst2 line_resp", line_resp, 1'b1);
    check("held burst2 line_rdata", line_rdata, exp_line);
    line_read = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    check("held line_resp low", line_resp, 1'b0);
    check("held resp count", resp_cnt - cnt0, 2);

`ifdef LINE_BURST_ADAPTOR_WATCHDOG_EN
    // Watchdog: mem_resp never arrives.
    line_read = 1'b1; line_address = 32'h0000_3000; mem_resp = 1'b0;
    repeat (8) @(negedge clk);
    check("wd 8th stall mem_read", mem_read, 1'b1);
    check("wd 8th stall error", error, 1'b0);
    @(negedge clk);
    check("wd line_resp", line_resp, 1'b1);
    check("wd error", error, 1'b1);
    check("wd line_rdata", line_rdata, 256'h0);
    line_read = 1'b0;
    repeat (3) @(negedge clk);
    check("wd error sticky", error, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("wd error cleared", error, 1'b0);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
